// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded CPU: opcodes, control-word layout, widths.
`timescale 1ns/1ps
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned CW_W       = 17;

    typedef enum logic [3:0] {
        OP_NOP     = 4'b0000,
        OP_LOADA   = 4'b0001,
        OP_ADD     = 4'b0010,
        OP_SUB     = 4'b0011,
        OP_STOREA  = 4'b0100,
        OP_LOAD_IM = 4'b0101,
        OP_JUMP    = 4'b0110,
        OP_OUT     = 4'b1110,
        OP_HALT    = 4'b1111
    } opcode_t;

    // Bit positions of each strobe inside the 17-bit control word.
    localparam int unsigned CW_CLK_HALT = 16;
    localparam int unsigned CW_PC_OUT   = 15;
    localparam int unsigned CW_PC_INC   = 14;
    localparam int unsigned CW_PC_JUMP  = 13;
    localparam int unsigned CW_A_IN     = 12;
    localparam int unsigned CW_A_OUT    = 11;
    localparam int unsigned CW_B_IN     = 10;
    localparam int unsigned CW_B_OUT    = 9;
    localparam int unsigned CW_I_IN     = 8;
    localparam int unsigned CW_I_OUT    = 7;
    localparam int unsigned CW_MAR_IN   = 6;
    localparam int unsigned CW_RAM_IN   = 5;
    localparam int unsigned CW_RAM_OUT  = 4;
    localparam int unsigned CW_ALU_OUT  = 3;
    localparam int unsigned CW_ALU_SUB  = 2;
    localparam int unsigned CW_FLAGS_IN = 1;
    localparam int unsigned CW_OUT_EN   = 0;

endpackage

// File: rtl/datapath_alu.sv
// Combinational add/subtract unit; subtraction is A + ~B + 1.
`timescale 1ns/1ps
module alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);

    logic [DATA_W:0] w_sum;

    // Extended-width sum gives the carry out directly.
    always_comb begin
        w_sum    = {1'b0, i_a} + {1'b0, (i_sub ? ~i_b : i_b)} + {{DATA_W{1'b0}}, i_sub};
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
        o_zero   = (w_sum[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/datapath.sv
// CPU datapath: shared bus, PC, A/B, IR, MAR, RAM, ALU, flags and output register.
`timescale 1ns/1ps
module datapath
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned RAM_INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_halt,
    input  logic              pc_out,
    input  logic              pc_inc,
    input  logic              pc_jump,
    input  logic              a_reg_read_from_bus,
    input  logic              a_reg_write_to_bus,
    input  logic              b_reg_read_from_bus,
    input  logic              b_reg_write_to_bus,
    input  logic              i_reg_read_from_bus,
    input  logic              i_reg_write_to_bus,
    input  logic              mar_read_from_bus,
    input  logic              ram_read_from_bus,
    input  logic              ram_write_to_bus,
    input  logic              alu_out,
    input  logic              alu_subtract,
    input  logic              alu_flags_in,
    input  logic              out_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        instruction,
    output logic              alu_carry,
    output logic              alu_zero,
    output logic [DATA_W-1:0] out_value,
    output logic              halted,
    output logic              bus_conflict,
    output logic [DATA_W-1:0] bus_dbg
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] r_pc, r_mar;
    logic [DATA_W-1:0] r_a, r_b, r_ir, r_out;
    logic              r_carry, r_zero, r_halted, r_conflict;
    logic [DATA_W-1:0] r_ram [DEPTH];

    logic [DATA_W-1:0] w_bus, w_alu_res, w_ram_rd, w_ram_wdata;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic              w_alu_carry, w_alu_zero, w_multi, w_ram_we;

    alu #(.DATA_W(DATA_W)) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sub    (alu_subtract),
        .o_result (w_alu_res),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    assign w_ram_rd = r_ram[r_mar];

    // Bus is the OR of all enabled drivers; more than one driver is a conflict.
    always_comb begin
        w_bus = '0;
        if (pc_out)             w_bus = w_bus | DATA_W'(r_pc);
        if (i_reg_write_to_bus) w_bus = w_bus | DATA_W'(r_ir[3:0]);
        if (a_reg_write_to_bus) w_bus = w_bus | r_a;
        if (b_reg_write_to_bus) w_bus = w_bus | r_b;
        if (ram_write_to_bus)   w_bus = w_bus | w_ram_rd;
        if (alu_out)            w_bus = w_bus | w_alu_res;
        w_multi = ($countones({pc_out, i_reg_write_to_bus, a_reg_write_to_bus,
                               b_reg_write_to_bus, ram_write_to_bus, alu_out}) > 1);
    end

    // RAM write port arbitration: host load beats the CPU store; host ignores halt.
    always_comb begin
        w_ram_we    = prog_we | (~r_halted & ram_read_from_bus);
        w_ram_waddr = prog_we ? prog_addr : r_mar;
        w_ram_wdata = prog_we ? prog_data : w_bus;
    end

    // Register file, flags and status; strobe-driven loads are frozen while halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_mar      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_ir       <= '0;
            r_out      <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_halted   <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            if (w_multi)  r_conflict <= 1'b1;
            if (clk_halt) r_halted   <= 1'b1;
            if (!r_halted) begin
                if (a_reg_read_from_bus) r_a   <= w_bus;
                if (b_reg_read_from_bus) r_b   <= w_bus;
                if (i_reg_read_from_bus) r_ir  <= w_bus;
                if (mar_read_from_bus)   r_mar <= w_bus[ADDR_W-1:0];
                if (out_en)              r_out <= w_bus;
                if (pc_jump)             r_pc  <= w_bus[ADDR_W-1:0];
                else if (pc_inc)         r_pc  <= r_pc + ADDR_W'(1);
                if (alu_flags_in) begin
                    r_carry <= w_alu_carry;
                    r_zero  <= w_alu_zero;
                end
            end
        end
    end

    generate
        if (RAM_INIT_ZERO != 0) begin : g_ram_clr
            // RAM storage, cleared by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) r_ram[i] <= '0;
                end else if (w_ram_we) begin
                    r_ram[w_ram_waddr] <= w_ram_wdata;
                end
            end
        end else begin : g_ram_keep
            // RAM storage, contents survive reset.
            always_ff @(posedge clk) begin
                if (w_ram_we) r_ram[w_ram_waddr] <= w_ram_wdata;
            end
        end
    endgenerate

    assign instruction  = r_ir[DATA_W-1 -: 4];
    assign alu_carry    = r_carry;
    assign alu_zero     = r_zero;
    assign out_value    = r_out;
    assign halted       = r_halted;
    assign bus_conflict = r_conflict;
    assign bus_dbg      = w_bus;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath with an expectation queue checked at each sample point.
`timescale 1ns/1ps
module tb_datapath;
    import cpu_pkg::*;

    localparam logic [16:0] HLT    = 17'(1) << CW_CLK_HALT;
    localparam logic [16:0] PC_OUT = 17'(1) << CW_PC_OUT;
    localparam logic [16:0] PC_INC = 17'(1) << CW_PC_INC;
    localparam logic [16:0] PC_JMP = 17'(1) << CW_PC_JUMP;
    localparam logic [16:0] A_IN   = 17'(1) << CW_A_IN;
    localparam logic [16:0] A_OUT  = 17'(1) << CW_A_OUT;
    localparam logic [16:0] B_IN   = 17'(1) << CW_B_IN;
    localparam logic [16:0] I_IN   = 17'(1) << CW_I_IN;
    localparam logic [16:0] I_OUT  = 17'(1) << CW_I_OUT;
    localparam logic [16:0] MAR_IN = 17'(1) << CW_MAR_IN;
    localparam logic [16:0] RAM_OUT= 17'(1) << CW_RAM_OUT;
    localparam logic [16:0] ALU_O  = 17'(1) << CW_ALU_OUT;
    localparam logic [16:0] SUB    = 17'(1) << CW_ALU_SUB;
    localparam logic [16:0] FL_IN  = 17'(1) << CW_FLAGS_IN;
    localparam logic [16:0] OUT_EN = 17'(1) << CW_OUT_EN;

    logic        clk, rst;
    logic [16:0] ctl;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  instruction;
    logic        alu_carry, alu_zero, halted, bus_conflict;
    logic [7:0]  out_value, bus_dbg;

    logic [7:0]  exp_q[$];
    string       tag_q[$];
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;

    datapath #(.DATA_W(8), .ADDR_W(4), .RAM_INIT_ZERO(1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .clk_halt            (ctl[CW_CLK_HALT]),
        .pc_out              (ctl[CW_PC_OUT]),
        .pc_inc              (ctl[CW_PC_INC]),
        .pc_jump             (ctl[CW_PC_JUMP]),
        .a_reg_read_from_bus (ctl[CW_A_IN]),
        .a_reg_write_to_bus  (ctl[CW_A_OUT]),
        .b_reg_read_from_bus (ctl[CW_B_IN]),
        .b_reg_write_to_bus  (ctl[CW_B_OUT]),
        .i_reg_read_from_bus (ctl[CW_I_IN]),
        .i_reg_write_to_bus  (ctl[CW_I_OUT]),
        .mar_read_from_bus   (ctl[CW_MAR_IN]),
        .ram_read_from_bus   (ctl[CW_RAM_IN]),
        .ram_write_to_bus    (ctl[CW_RAM_OUT]),
        .alu_out             (ctl[CW_ALU_OUT]),
        .alu_subtract        (ctl[CW_ALU_SUB]),
        .alu_flags_in        (ctl[CW_FLAGS_IN]),
        .out_en              (ctl[CW_OUT_EN]),
        .prog_we             (prog_we),
        .prog_addr           (prog_addr),
        .prog_data           (prog_data),
        .instruction         (instruction),
        .alu_carry           (alu_carry),
        .alu_zero            (alu_zero),
        .out_value           (out_value),
        .halted              (halted),
        .bus_conflict        (bus_conflict),
        .bus_dbg             (bus_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [7:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [7:0] obs);
        string      t;
        logic [7:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0x%02h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s observed=0x%02h expected=0x%02h", t, obs, e);
            end
        end
    endtask

    // Drive strobes at negedge, return 1ns after the following posedge.
    task automatic step(input logic [16:0] c, input logic pw = 1'b0,
                        input logic [3:0] pa = 4'd0, input logic [7:0] pd = 8'd0);
        @(negedge clk);
        ctl = c; prog_we = pw; prog_addr = pa; prog_data = pd;
        @(posedge clk);
        #1;
    endtask

    // Combinational look at the bus during the low phase.
    task automatic peek(input logic [16:0] c, input string tag, input logic [7:0] e);
        @(negedge clk);
        ctl = c; prog_we = 1'b0;
        expect_val(tag, e);
        #1;
        check(bus_dbg);
        ctl = '0;
    endtask

    // Host-write a value at address mar (the current MAR), then move it over the bus.
    task automatic ld(input logic [16:0] dst, input logic [3:0] mar, input logic [7:0] v);
        step('0, 1'b1, mar, v);
        step(RAM_OUT | dst);
    endtask

    initial begin
        rst = 1'b1; ctl = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_val("rst_out_value", 8'h00);  check(out_value);
        expect_val("rst_halted", 8'h00);     check(8'(halted));
        expect_val("rst_conflict", 8'h00);   check(8'(bus_conflict));
        expect_val("rst_instr", 8'h00);      check(8'(instruction));
        expect_val("rst_bus", 8'h00);        check(bus_dbg);
        @(negedge clk);
        rst = 1'b0;

        // Program: LOADA 14, ADD 15, data 5 and 3
        step('0, 1'b1, 4'd0, 8'h1E);
        step('0, 1'b1, 4'd1, 8'h2F);
        step('0, 1'b1, 4'd14, 8'h05);
        step('0, 1'b1, 4'd15, 8'h03);

        step(PC_OUT | MAR_IN);
        expect_val("ir_loada", 8'h01);
        step(RAM_OUT | I_IN | PC_INC);
        check(8'(instruction));
        step(I_OUT | MAR_IN);
        step(RAM_OUT | A_IN);
        peek(A_OUT, "a_loada", 8'h05);

        step(PC_OUT | MAR_IN);
        expect_val("ir_add", 8'h02);
        step(RAM_OUT | I_IN | PC_INC);
        check(8'(instruction));
        step(I_OUT | MAR_IN);
        step(RAM_OUT | B_IN);
        expect_val("add_carry", 8'h00);
        expect_val("add_zero", 8'h00);
        step(ALU_O | A_IN | FL_IN);
        check(8'(alu_carry));
        check(8'(alu_zero));
        peek(A_OUT, "a_add", 8'h08);
        peek(PC_OUT, "pc_after_two_fetches", 8'h02);

        // 3 - 3 with A read-modify-write
        ld(A_IN, 4'd15, 8'h03);
        ld(B_IN, 4'd15, 8'h03);
        expect_val("sub_carry", 8'h01);
        expect_val("sub_zero", 8'h01);
        step(ALU_O | SUB | A_IN | FL_IN);
        check(8'(alu_carry));
        check(8'(alu_zero));
        peek(A_OUT, "a_sub", 8'h00);

        // Flags hold without alu_flags_in
        ld(A_IN, 4'd15, 8'h10);
        ld(B_IN, 4'd15, 8'h20);
        expect_val("hold_carry", 8'h01);
        expect_val("hold_zero", 8'h01);
        step(ALU_O | A_IN);
        check(8'(alu_carry));
        check(8'(alu_zero));
        peek(A_OUT, "a_noflags", 8'h30);
        expect_val("plain_carry", 8'h00);
        expect_val("plain_zero", 8'h00);
        step(ALU_O | A_IN | FL_IN);
        check(8'(alu_carry));
        check(8'(alu_zero));
        peek(A_OUT, "a_plain", 8'h50);

        // 0xFF + 0x01 wraps to zero
        ld(A_IN, 4'd15, 8'hFF);
        ld(B_IN, 4'd15, 8'h01);
        expect_val("wrap_carry", 8'h01);
        expect_val("wrap_zero", 8'h01);
        step(ALU_O | A_IN | FL_IN);
        check(8'(alu_carry));
        check(8'(alu_zero));
        peek(A_OUT, "a_wrap", 8'h00);

        // PC wrap and jump priority
        ld(PC_JMP, 4'd15, 8'h0F);
        peek(PC_OUT, "pc_jump15", 8'h0F);
        step(PC_INC);
        peek(PC_OUT, "pc_inc_wrap", 8'h00);
        ld(PC_JMP | PC_INC, 4'd15, 8'h09);
        peek(PC_OUT, "pc_jump_over_inc", 8'h09);

        // Output register
        expect_val("out_load", 8'h5A);
        ld(OUT_EN, 4'd15, 8'h5A);
        check(out_value);

        // Two bus drivers
        ld(PC_JMP, 4'd15, 8'h02);
        ld(A_IN, 4'd15, 8'h11);
        @(negedge clk);
        ctl = PC_OUT | A_OUT;
        expect_val("bus_or", 8'h13);
        expect_val("conflict_pre", 8'h00);
        #1;
        check(bus_dbg);
        check(8'(bus_conflict));
        expect_val("conflict_set", 8'h01);
        @(posedge clk);
        #1;
        check(8'(bus_conflict));
        step('0);
        expect_val("conflict_sticky", 8'h01);
        check(8'(bus_conflict));

        // Halt: point MAR at 3, load A, then halt
        step('0, 1'b1, 4'd15, 8'h03);
        step(RAM_OUT | MAR_IN);
        ld(A_IN, 4'd3, 8'h2A);
        expect_val("halted_set", 8'h01);
        step(HLT);
        check(8'(halted));
        @(negedge clk);
        ctl = OUT_EN | A_OUT;
        expect_val("halted_bus", 8'h2A);
        expect_val("halted_out_hold", 8'h5A);
        #1;
        check(bus_dbg);
        @(posedge clk);
        #1;
        check(out_value);
        step('0, 1'b1, 4'd3, 8'h77);
        peek(RAM_OUT, "halted_prog_write", 8'h77);
        step(RAM_OUT | A_IN);
        peek(A_OUT, "halted_a_hold", 8'h2A);
        step(PC_INC);
        peek(PC_OUT, "halted_pc_hold", 8'h02);
        expect_val("halted_sticky", 8'h01);
        check(8'(halted));

        // Asynchronous reset in the low phase
        @(negedge clk);
        #2;
        rst = 1'b1;
        expect_val("arst_halted", 8'h00);
        expect_val("arst_conflict", 8'h00);
        expect_val("arst_out", 8'h00);
        expect_val("arst_carry", 8'h00);
        expect_val("arst_zero", 8'h00);
        expect_val("arst_instr", 8'h00);
        #1;
        check(8'(halted));
        check(8'(bus_conflict));
        check(out_value);
        check(8'(alu_carry));
        check(8'(alu_zero));
        check(8'(instruction));
        peek(A_OUT, "arst_a", 8'h00);
        peek(PC_OUT, "arst_pc", 8'h00);
        peek(RAM_OUT, "arst_ram0", 8'h00);
        rst = 1'b0;

        if (exp_q.size() != 0) begin
            n_total++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Bus-side responder to the microcoded control unit: consumes the 17 control strobes and implements the 8-bit shared bus, PC, A/B registers, IR, MAR, 16x8 RAM, ALU, flags register and output register.
- Returns the opcode nibble and the latched ALU flags to the control unit, closing the control/datapath loop.
- Includes a host program-load port so RAM can be filled before run.

Parameters:
- DATA_W, 8, bus/register width
- ADDR_W, 4, PC/MAR width; RAM depth is 2**ADDR_W
- RAM_INIT_ZERO, 1, when 1, RAM contents are cleared to 0 at reset

Ports:
- clk  in  1  system clock; all state updates on posedge (control strobes change on negedge)
- rst  in  1  asynchronous, active-high reset
- clk_halt, pc_out, pc_inc, pc_jump, a_reg_read_from_bus, a_reg_write_to_bus, b_reg_read_from_bus, b_reg_write_to_bus, i_reg_read_from_bus, i_reg_write_to_bus, mar_read_from_bus, ram_read_from_bus, ram_write_to_bus, alu_out, alu_subtract, alu_flags_in, out_en  in  1 each  control strobes ("write_to_bus" = drive bus, "read_from_bus" = latch bus)
- prog_we  in  1  host RAM write strobe
- prog_addr  in  ADDR_W  host RAM address
- prog_data  in  DATA_W  host RAM data
- instruction  out  4  IR[7:4]
- alu_carry  out  1  latched carry flag
- alu_zero  out  1  latched zero flag
- out_value  out  DATA_W  output register
- halted  out  1  sticky halt status
- bus_conflict  out  1  sticky multiple-driver error
- bus_dbg  out  DATA_W  current bus value

Behaviour:
- Reset (async): PC, A, B, IR, MAR, flags, out_value, halted, bus_conflict = 0. RAM = 0 if RAM_INIT_ZERO, else retained.
- Bus is combinational from the drivers:
  - pc_out drives {0,PC}; i_reg_write_to_bus drives {0,IR[3:0]}; A, B, RAM[MAR] and ALU result drive full width.
  - No driver: bus = 0. More than one driver: bus = OR of driver values, and bus_conflict sets on the next posedge and stays set until reset.
- ALU: 9-bit sum = A + (alu_subtract ? ~B : B) + alu_subtract.
  - Result = sum[7:0]; carry = sum[8]; zero = (result == 0).
  - Flags register loads carry and zero on posedge when alu_flags_in is high; otherwise it holds.
- Posedge loads, all from the pre-edge bus value:
  - A, B, IR load on their read_from_bus strobes; MAR loads bus[3:0]; RAM[MAR] loads the bus on ram_read_from_bus; out_value loads the bus on out_en.
  - A and alu_out in the same cycle: A takes the old-A result (single-cycle read-modify-write).
- PC priority: pc_jump (load bus[3:0]) over pc_inc. Increment wraps 15 -> 0. Zero latency; new value visible after the edge.
- Halt:
  - clk_halt sampled at posedge sets halted.
  - While halted, all register, flag and RAM updates from control strobes are suppressed. The bus and ALU stay combinational. Only rst clears halted.
- Program port: prog_we writes RAM[prog_addr] on posedge regardless of halted.
  - If prog_we and ram_read_from_bus hit the same cycle, the host write wins and the CPU write is dropped.
- RAM read is asynchronous (RAM[MAR] is visible on the bus in the same cycle as ram_write_to_bus).
- instruction always reflects IR[7:4]. Outputs are registered state except bus_dbg.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (LOADA 0001, ADD 0010, SUB 0011, STOREA 0100, LOAD_IM 0101, JUMP 0110, OUT 1110, HALT 1111);
  - the 17-bit control-word bit positions;
  - DATA_W and ADDR_W defaults.
- One sub-module, alu: combinational add/sub with result, carry and zero.

Test Plan:
- Reset mid-run with A=0x3C, PC=7, halted=1 -> all outputs 0 immediately, independent of clk.
- Preload RAM[14]=0x05 and RAM[15]=0x03 via the program port; drive the LOADA 14 then ADD 15 microsequence -> A=0x08, alu_carry=0, alu_zero=0.
- A=0x03, B=0x03, alu_subtract=1, alu_out=1, alu_flags_in=1, a_reg_read_from_bus=1 -> A=0x00, carry=1, zero=1. Then A=0xFF, B=0x01 add -> A=0x00, carry=1, zero=1.
- PC=15 with pc_inc -> PC=0. Bus=0x09 with pc_jump and pc_inc together -> PC=9.
- Assert pc_out and a_reg_write_to_bus with PC=2, A=0x11 -> bus_dbg=0x13, bus_conflict=1 after the edge and stays 1.
- clk_halt pulse, then out_en with A=0x2A driving the bus -> halted=1, out_value unchanged at 0. A prog_we to address 3 in the same halted state still writes RAM.
